gb_timer_multi: RTL and testbench



---
 rtl/gb_timer_multi.sv | 167 ++++++++++++++++
 tb/tb_gb_timer_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_timer_multi.sv
// gb_timer_multi: shared 16-bit DIV counter plus NUM_CH independent TIMA/TMA/TAC channels on the MMIO bus.
// Optional feature macro TIMER_ONESHOT_EN: enables TAC[3] one-shot auto-disable; otherwise TAC[3] reads 1.
module gb_timer_multi #(
  parameter int          NUM_CH     = 2,
  parameter logic [15:0] BASE_ADDR  = 16'hFF04,
  parameter int          RELOAD_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ADDR,
  input  logic              WR,
  input  logic              RD,
  input  logic [7:0]        MMIO_DATA_out,
  output logic [7:0]        MMIO_DATA_in,
  output logic [NUM_CH-1:0] IRQ_TIMER
);
  typedef enum logic [1:0] {ST_RUN, ST_OVF, ST_RELOAD} ch_state_e;

`ifdef TIMER_ONESHOT_EN
  localparam logic TAC3_RST = 1'b0;
`else
  localparam logic TAC3_RST = 1'b1;
`endif
  // OVF lasts RELOAD_DLY-1 cycles, so the reload edge is taken when dly holds RELOAD_DLY-2
  localparam logic [3:0] DLY_LAST = 4'(RELOAD_DLY - 2);

  logic [15:0]            divcnt_q, divcnt_d;
  logic [NUM_CH-1:0][7:0] tima_q, tima_d;
  logic [NUM_CH-1:0][7:0] tma_q, tma_d;
  logic [NUM_CH-1:0][3:0] tac_q, tac_d;
  logic [NUM_CH-1:0][3:0] dly_q, dly_d;
  logic [NUM_CH-1:0]      sel_prev_q, sel_prev_d;
  ch_state_e              state_q [NUM_CH];
  ch_state_e              state_d [NUM_CH];

  logic                   div_wr;
  logic [NUM_CH-1:0]      wr_tima, wr_tma, wr_tac;
  logic [NUM_CH-1:0]      tick, reload_now;
  logic                   unused_rd;

  assign unused_rd = RD;

  function automatic logic tap_bit(input logic [3:0] taps, input logic [1:0] mode);
    // taps = {div[9], div[7], div[5], div[3]}
    case (mode)
      2'b00:   tap_bit = taps[3];
      2'b01:   tap_bit = taps[0];
      2'b10:   tap_bit = taps[1];
      default: tap_bit = taps[2];
    endcase
  endfunction

  // Address decode: write strobes and combinational read mux
  always_comb begin
    div_wr       = WR && (ADDR == BASE_ADDR);
    wr_tima      = '0;
    wr_tma       = '0;
    wr_tac       = '0;
    MMIO_DATA_in = 8'hFF;
    if (ADDR == BASE_ADDR) MMIO_DATA_in = divcnt_q[15:8];
    for (int c = 0; c < NUM_CH; c++) begin
      wr_tima[c] = WR && (ADDR == BASE_ADDR + 16'(1 + 3 * c));
      wr_tma[c]  = WR && (ADDR == BASE_ADDR + 16'(2 + 3 * c));
      wr_tac[c]  = WR && (ADDR == BASE_ADDR + 16'(3 + 3 * c));
      if (ADDR == BASE_ADDR + 16'(1 + 3 * c)) MMIO_DATA_in = tima_q[c];
      if (ADDR == BASE_ADDR + 16'(2 + 3 * c)) MMIO_DATA_in = tma_q[c];
      if (ADDR == BASE_ADDR + 16'(3 + 3 * c)) MMIO_DATA_in = {4'hF, tac_q[c]};
    end
  end

  always_comb begin
    logic [8:0] inc;
    inc        = '0;
    divcnt_d   = div_wr ? 16'h0000 : divcnt_q + 16'h0001;
    tima_d     = tima_q;
    tma_d      = tma_q;
    tac_d      = tac_q;
    dly_d      = dly_q;
    sel_prev_d = '0;
    tick       = '0;
    reload_now = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      inc        = {1'b0, tima_q[c]} + 9'd1;
      if (wr_tma[c]) tma_d[c] = MMIO_DATA_out;
`ifdef TIMER_ONESHOT_EN
      if (wr_tac[c]) tac_d[c] = MMIO_DATA_out[3:0];
`else
      if (wr_tac[c]) tac_d[c] = {1'b1, MMIO_DATA_out[2:0]};
`endif
      reload_now[c] = (state_q[c] == ST_OVF) && (dly_q[c] == DLY_LAST) && !wr_tima[c];
`ifdef TIMER_ONESHOT_EN
      if (reload_now[c] && tac_d[c][3]) tac_d[c][2] = 1'b0;
`endif
      // Edge detect uses post-write TAC and DIV, so DIV/TAC writes can produce a tick
      sel_prev_d[c] = tap_bit({divcnt_d[9], divcnt_d[7], divcnt_d[5], divcnt_d[3]},
                              tac_d[c][1:0]) & tac_d[c][2];
      tick[c] = sel_prev_q[c] & ~sel_prev_d[c];
      case (state_q[c])
        ST_OVF: begin
          if (wr_tima[c]) begin
            tima_d[c]  = MMIO_DATA_out;
            state_d[c] = ST_RUN;
          end else if (reload_now[c]) begin
            tima_d[c]  = tma_d[c];
            state_d[c] = ST_RELOAD;
          end else begin
            dly_d[c] = dly_q[c] + 4'd1;
            if (tick[c]) begin
              tima_d[c] = inc[7:0];
              if (inc[8]) dly_d[c] = 4'd0;
            end
          end
        end
        ST_RELOAD: begin
          state_d[c] = ST_RUN;
          if (wr_tma[c]) begin
            tima_d[c] = MMIO_DATA_out;
          end else if (tick[c]) begin
            tima_d[c] = inc[7:0];
            if (inc[8]) begin
              state_d[c] = ST_OVF;
              dly_d[c]   = 4'd0;
            end
          end
        end
        default: begin
          if (wr_tima[c]) begin
            tima_d[c] = MMIO_DATA_out;
          end else if (tick[c]) begin
            tima_d[c] = inc[7:0];
            if (inc[8]) begin
              state_d[c] = ST_OVF;
              dly_d[c]   = 4'd0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) IRQ_TIMER[c] = (state_q[c] == ST_RELOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt_q   <= '0;
      tima_q     <= '0;
      tma_q      <= '0;
      dly_q      <= '0;
      sel_prev_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tac_q[c]   <= {TAC3_RST, 3'b000};
        state_q[c] <= ST_RUN;
      end
    end else begin
      divcnt_q   <= divcnt_d;
      tima_q     <= tima_d;
      tma_q      <= tma_d;
      tac_q      <= tac_d;
      dly_q      <= dly_d;
      sel_prev_q <= sel_prev_d;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
    end
  end
endmodule

// File: tb/tb_gb_timer_multi.sv
// Directed bench for gb_timer_multi (NUM_CH=2): stimulus pushes expected {IRQ_TIMER, read data} into a queue,
// a negedge monitor pops and compares on every RD cycle and on IRQ-count check requests.
module tb_gb_timer_multi;
  localparam int NUM_CH = 2;
  localparam int W      = NUM_CH + 8;

`ifdef TIMER_ONESHOT_EN
  localparam logic [7:0] TAC_RST_RD  = 8'hF0;
  localparam logic [7:0] TAC_OS_RD   = 8'hF9;
  localparam logic [7:0] TIMA_OS_END = 8'h3C;
`else
  localparam logic [7:0] TAC_RST_RD  = 8'hF8;
  localparam logic [7:0] TAC_OS_RD   = 8'hFD;
  localparam logic [7:0] TIMA_OS_END = 8'h3D;
`endif

  localparam logic [15:0] A_DIV   = 16'hFF04;
  localparam logic [15:0] A_TIMA0 = 16'hFF05;
  localparam logic [15:0] A_TMA0  = 16'hFF06;
  localparam logic [15:0] A_TAC0  = 16'hFF07;
  localparam logic [15:0] A_TIMA1 = 16'hFF08;
  localparam logic [15:0] A_TMA1  = 16'hFF09;
  localparam logic [15:0] A_TAC1  = 16'hFF0A;

  logic              clk;
  logic              rst;
  logic [15:0]       ADDR;
  logic              WR;
  logic              RD;
  logic [7:0]        MMIO_DATA_out;
  logic [7:0]        MMIO_DATA_in;
  logic [NUM_CH-1:0] IRQ_TIMER;

  gb_timer_multi #(.NUM_CH(NUM_CH), .BASE_ADDR(16'hFF04), .RELOAD_DLY(4)) dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(MMIO_DATA_out), .MMIO_DATA_in(MMIO_DATA_in), .IRQ_TIMER(IRQ_TIMER)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           cnt_exp_q[$];
  int           cnt_ch_q[$];
  string        cnt_name_q[$];
  logic         cnt_req;
  int           irq_cnt [NUM_CH];
  int           n_checks;
  int           n_pass;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int c = 0; c < NUM_CH; c++) irq_cnt[c] = 0;
  end

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    string nm;
    int ec;
    int ch;
    for (int c = 0; c < NUM_CH; c++) if (IRQ_TIMER[c] === 1'b1) irq_cnt[c]++;
    if (RD) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL read_underflow: read seen with no expected value, got data=%h", MMIO_DATA_in);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({IRQ_TIMER, MMIO_DATA_in} === e) n_pass++;
        else $display("FAIL %s: got irq=%b data=%h, expected irq=%b data=%h",
                      nm, IRQ_TIMER, MMIO_DATA_in, e[W-1:8], e[7:0]);
      end
    end
    if (cnt_req) begin
      n_checks++;
      if (cnt_exp_q.size() == 0) begin
        $display("FAIL cnt_underflow: count request with no expected value");
      end else begin
        ec = cnt_exp_q.pop_front();
        ch = cnt_ch_q.pop_front();
        nm = cnt_name_q.pop_front();
        if (irq_cnt[ch] == ec) n_pass++;
        else $display("FAIL %s: got irq count %0d, expected %0d", nm, irq_cnt[ch], ec);
      end
    end
  end

  // driver tasks: each is entered 1ns after a rising edge and consumes one clock
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = a; MMIO_DATA_out = d; WR = 1'b1;
    @(posedge clk); #1;
    WR = 1'b0; ADDR = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [NUM_CH-1:0] irq,
                        input logic [7:0] d, input string nm);
    ADDR = a; RD = 1'b1;
    exp_q.push_back({irq, d});
    name_q.push_back(nm);
    @(posedge clk); #1;
    RD = 1'b0; ADDR = 16'h0000;
  endtask

  task automatic irq_chk(input int ch, input int expc, input string nm);
    cnt_exp_q.push_back(expc);
    cnt_ch_q.push_back(ch);
    cnt_name_q.push_back(nm);
    cnt_req = 1'b1;
    @(posedge clk); #1;
    cnt_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; WR = 1'b0; RD = 1'b0; ADDR = 16'h0000; MMIO_DATA_out = 8'h00; cnt_req = 1'b0;
    @(posedge clk); #1;

    // reset state, read while rst is held so DIV stays 0
    rd_chk(A_DIV,   2'b00, 8'h00, "rst_div");
    rd_chk(A_TIMA0, 2'b00, 8'h00, "rst_tima0");
    rd_chk(A_TMA0,  2'b00, 8'h00, "rst_tma0");
    rd_chk(A_TAC0,  2'b00, TAC_RST_RD, "rst_tac0");
    rd_chk(A_TIMA1, 2'b00, 8'h00, "rst_tima1");
    rd_chk(A_TMA1,  2'b00, 8'h00, "rst_tma1");
    rd_chk(A_TAC1,  2'b00, TAC_RST_RD, "rst_tac1");
    rd_chk(16'hFF0B, 2'b00, 8'hFF, "rst_unmapped_ff0b");
    rd_chk(16'hFF03, 2'b00, 8'hFF, "rst_unmapped_ff03");
    rst = 1'b0;

    // ch0 TAC=05 TMA=AB TIMA=FE: ticks on DIV[3] falling, every 16 clocks
    wr(A_TMA0, 8'hAB);
    wr(A_TIMA0, 8'hFE);
    wr(A_DIV, 8'h5A);                 // k=0
    wr(A_TAC0, 8'h05);                // k=1
    idle(14);                         // k=15
    rd_chk(A_TIMA0, 2'b00, 8'hFE, "a_before_tick");
    rd_chk(A_TIMA0, 2'b00, 8'hFF, "a_first_tick");
    idle(16);                         // k=33, overflow tick was at edge 32
    rd_chk(A_TIMA0, 2'b00, 8'h00, "a_ovf_dly1");
    rd_chk(A_TIMA0, 2'b00, 8'h00, "a_ovf_dly2");
    rd_chk(A_TIMA0, 2'b01, 8'hAB, "a_reload_irq");
    rd_chk(A_TIMA0, 2'b00, 8'hAB, "a_after_reload");
    wr(A_TAC0, 8'h00);
    irq_chk(0, 1, "a_irq0_count");

    // DIV write while DIV[3]=1 gives exactly one tick
    wr(A_DIV, 8'h00);                 // k=0
    wr(A_TIMA0, 8'h10);               // k=1
    wr(A_TAC0, 8'h05);                // k=2
    idle(8);                          // k=10
    rd_chk(A_TIMA0, 2'b00, 8'h10, "b_pre_div_wr");
    wr(A_DIV, 8'hFF);                 // sampled with DIV=11, new base k=0
    rd_chk(A_TIMA0, 2'b00, 8'h11, "b_div_wr_tick");
    idle(4);
    rd_chk(A_TIMA0, 2'b00, 8'h11, "b_div_wr_single");
    idle(4);                          // k=10, DIV[3]=1
    wr(A_TAC0, 8'h01);                // disable while tap high
    rd_chk(A_TIMA0, 2'b00, 8'h12, "b_tac_dis_tick");
    idle(10);
    rd_chk(A_TIMA0, 2'b00, 8'h12, "b_tac_dis_single");

    // ch1 overflow then TIMA write two clocks later cancels reload
    wr(A_TAC1, 8'h00);
    wr(A_TMA1, 8'h5A);
    wr(A_TIMA1, 8'hFF);
    wr(A_DIV, 8'h00);                 // k=0
    wr(A_TAC1, 8'h05);                // k=1
    idle(15);                         // k=16
    rd_chk(A_TIMA1, 2'b00, 8'h00, "c_ovf_tima1");
    wr(A_TIMA1, 8'h42);               // sampled at N+2
    rd_chk(A_TIMA1, 2'b00, 8'h42, "c_cancel_tima1");
    idle(5);
    rd_chk(A_TIMA1, 2'b00, 8'h42, "c_cancel_hold");
    irq_chk(1, 0, "c_cancel_no_irq");

    // TIMA write in the RELOAD cycle is ignored
    wr(A_TAC1, 8'h00);
    wr(A_TIMA1, 8'hFF);
    wr(A_DIV, 8'h00);                 // k=0
    wr(A_TAC1, 8'h05);                // k=1
    idle(18);                         // k=19 is the RELOAD cycle
    wr(A_TIMA1, 8'h42);
    rd_chk(A_TIMA1, 2'b00, 8'h5A, "c_reload_wr_ignored");
    irq_chk(1, 1, "c_reload_irq_fired");

    // TMA write in the RELOAD cycle also lands in TIMA
    wr(A_TAC1, 8'h00);
    wr(A_TIMA1, 8'hFF);
    wr(A_DIV, 8'h00);
    wr(A_TAC1, 8'h05);
    idle(18);
    wr(A_TMA1, 8'h77);
    rd_chk(A_TIMA1, 2'b00, 8'h77, "d_tma_wr_tima");
    rd_chk(A_TMA1, 2'b00, 8'h77, "d_tma_wr_tma");
    irq_chk(1, 2, "d_irq_fired");

    // TAC=0D with TIMA=FF: one-shot when built with the feature, periodic otherwise
    wr(A_TAC1, 8'h00);
    wr(A_TMA1, 8'h3C);
    wr(A_TIMA1, 8'hFF);
    wr(A_DIV, 8'h00);                 // k=0
    wr(A_TAC1, 8'h0D);                // k=1
    rd_chk(A_TAC1, 2'b00, 8'hFD, "e_tac_readback");
    idle(17);                         // k=19
    rd_chk(A_TIMA1, 2'b10, 8'h3C, "e_reload_irq1");
    rd_chk(A_TAC1, 2'b00, TAC_OS_RD, "e_tac_after_reload");
    idle(19);                         // k=40, past the tick at edge 32
    rd_chk(A_TIMA1, 2'b00, TIMA_OS_END, "e_tima_later");
    irq_chk(1, 3, "e_irq1_count");
    irq_chk(0, 1, "e_irq0_count");

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
